spi_slave_rx_tx: RTL and testbench

Mode-0 SPI slave that sits on the far end of the bus driven by the `SPI_Interface` master. It receives `mosi` bytes into `rx_data` and returns bytes from a one-deep transmit buffer on `miso`. All pins are synchronised and edge-detected inside the single `clk` domain; no logic is clocked by `sck`. It is the bus-side target used for loopback and system bring-up against the master.

---
 rtl/spi_slave_rx_tx.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: mode-0 SPI slave running entirely in the clk domain.
// SPI pins are synchronised and edge-detected. MOSI words land in rx_data.
// MISO returns words from a one-deep transmit buffer, and IDLE_BYTE is sent
// whenever that buffer is empty at the start of a word.
module spi_slave_rx_tx #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ss,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);
    localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_WAIT_DESEL = 2'd0;
    localparam logic [1:0] ST_IDLE       = 2'd1;
    localparam logic [1:0] ST_LOAD       = 2'd2;
    localparam logic [1:0] ST_SHIFT      = 2'd3;

    logic [2:0]            ss_sync;
    logic [2:0]            sck_sync;
    logic [1:0]            mosi_sync;
    logic                  sel_fall;
    logic                  sel_rise;
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  ss_low;
    logic                  mosi_bit;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  load_pending;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] tx_shift_next;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic                  do_load;
    logic                  shift_in;
    logic                  word_done;

    // Two-flop synchronisers, plus a third history flop on ss and sck for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
        end else begin
            ss_sync   <= {ss_sync[1:0], ss};
            sck_sync  <= {sck_sync[1:0], sck};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign sel_fall = ss_sync[2] & ~ss_sync[1];
    assign sel_rise = ~ss_sync[2] & ss_sync[1];
    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign ss_low   = ~ss_sync[1];
    assign mosi_bit = mosi_sync[1];
    assign rx_word  = {rx_shift[DATA_WIDTH-2:0], mosi_bit};

    // Next-state decode. A deselect edge overrides everything else.
    always_comb begin
        state_next    = state;
        do_load       = 1'b0;
        shift_in      = 1'b0;
        word_done     = 1'b0;
        tx_shift_next = tx_shift;
        if (sel_rise) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_WAIT_DESEL: if (!ss_low) state_next = ST_IDLE;
                ST_IDLE:       if (sel_fall) state_next = ST_LOAD;
                ST_LOAD: begin
                    do_load    = 1'b1;
                    state_next = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        shift_in  = 1'b1;
                        word_done = (bit_cnt == LAST_BIT);
                    end
                    if (sck_fall) begin
                        if (load_pending) begin
                            do_load = 1'b1;
                        end else begin
                            tx_shift_next = {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: state_next = ST_WAIT_DESEL;
            endcase
            if (do_load) begin
                tx_shift_next = tx_ready ? IDLE_BYTE : tx_buf;
            end
        end
    end

    // FSM, bit counter, and the receive and transmit shift registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_WAIT_DESEL;
            bit_cnt      <= '0;
            load_pending <= 1'b0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            state       <= state_next;
            tx_shift    <= tx_shift_next;
            rx_valid    <= word_done;
            tx_underrun <= do_load & tx_ready;
            if (sel_rise) begin
                bit_cnt      <= '0;
                load_pending <= 1'b0;
            end else if (do_load) begin
                bit_cnt      <= '0;
                load_pending <= 1'b0;
            end else if (shift_in) begin
                rx_shift <= rx_word;
                if (word_done) begin
                    rx_data      <= rx_word;
                    bit_cnt      <= '0;
                    load_pending <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // One-deep transmit buffer. A load from an empty buffer still reports underrun and keeps the new word.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ready <= 1'b1;
            tx_buf   <= '0;
        end else if (do_load && !tx_ready) begin
            tx_ready <= 1'b1;
        end else if (tx_load && tx_ready) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
        end
    end

    // Registered pin-side outputs. MISO is forced low unless a frame is in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            busy    <= 1'b0;
        end else begin
            miso    <= (ss_low && state_next == ST_SHIFT) ? tx_shift_next[DATA_WIDTH-1] : 1'b0;
            miso_oe <= ss_low;
            busy    <= ss_low && (state_next == ST_LOAD || state_next == ST_SHIFT);
        end
    end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// tb_spi_slave_rx_tx: drives spi_slave_rx_tx as a mode-0 master at clk/8.
// Received words are scoreboarded, and single-word frames come from a vector
// table. Frames end with ss rising together with the final sck fall.
module tb_spi_slave_rx_tx;
    logic       clk = 1'b0;
    logic       reset;
    logic       ss;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    int         rx_count = 0;
    int         ur_count = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_word;
    logic [7:0] exp_last_rx = 8'h00;

    typedef struct {
        logic [7:0] tx_byte;
        bit         do_load;
        logic [7:0] mosi_byte;
        logic [7:0] exp_miso;
        int         exp_underrun;
    } vec_t;

    vec_t vecs[4];

    spi_slave_rx_tx #(.DATA_WIDTH(8), .IDLE_BYTE(8'hFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .ss         (ss),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_underrun(tx_underrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every rx_valid cycle pops one expected word.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_count++;
            if (exp_rx_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL rx_unexpected got=%0h want=none", rx_data);
            end else begin
                exp_word = exp_rx_q.pop_front();
                checkOutput("rx_data_scoreboard", {24'h0, rx_data}, {24'h0, exp_word});
                exp_last_rx = exp_word;
            end
        end
        if (tx_underrun) ur_count++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic loadTx(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) checkOutput("tx_ready_timeout", {31'h0, tx_ready}, 32'h1);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        checkOutput("tx_ready_drop", {31'h0, tx_ready}, 32'h0);
    endtask

    task automatic startFrame();
        ss = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic sendWord(input logic [7:0] mo, input int nbits, input bit last, output logic [7:0] mi);
        mi = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            mosi = mo[7-k];
            repeat (4) @(negedge clk);
            mi[7-k] = miso;
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            if (last && k == nbits - 1) ss = 1'b1;
        end
        if (last) repeat (8) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        int         rx0;
        int         ur0;
        logic [7:0] got;
        if (v.do_load) loadTx(v.tx_byte);
        rx0 = rx_count;
        ur0 = ur_count;
        exp_rx_q.push_back(v.mosi_byte);
        startFrame();
        sendWord(v.mosi_byte, 8, 1'b1, got);
        checkOutput("miso_word", {24'h0, got}, {24'h0, v.exp_miso});
        checkOutput("rx_valid_count", rx_count - rx0, 1);
        checkOutput("underrun_count", ur_count - ur0, v.exp_underrun);
        checkOutput("rx_data_hold", {24'h0, rx_data}, {24'h0, v.mosi_byte});
        checkOutput("tx_ready_after", {31'h0, tx_ready}, 32'h1);
        checkOutput("busy_after", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int         rx0;
        int         ur0;
        logic [7:0] got1;
        logic [7:0] got2;

        vecs[0] = '{8'hA5, 1'b1, 8'h05, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b0, 8'h3C, 8'hFF, 1};
        vecs[2] = '{8'h5A, 1'b1, 8'hFF, 8'h5A, 0};
        vecs[3] = '{8'h00, 1'b1, 8'h96, 8'h00, 0};

        reset = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_miso", {31'h0, miso}, 32'h0);
        checkOutput("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        checkOutput("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        checkOutput("rst_rx_data", {24'h0, rx_data}, 32'h0);
        checkOutput("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        checkOutput("rst_tx_underrun", {31'h0, tx_underrun}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] single-word vectors");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("[TB] two-word frame");
        loadTx(8'h12);
        rx0 = rx_count;
        ur0 = ur_count;
        exp_rx_q.push_back(8'hC3);
        exp_rx_q.push_back(8'h5A);
        ss = 1'b0;
        loadTx(8'h34);
        checkOutput("busy_mid_frame", {31'h0, busy}, 32'h1);
        checkOutput("miso_oe_mid_frame", {31'h0, miso_oe}, 32'h1);
        sendWord(8'hC3, 8, 1'b0, got1);
        sendWord(8'h5A, 8, 1'b1, got2);
        checkOutput("two_word_miso0", {24'h0, got1}, 32'h12);
        checkOutput("two_word_miso1", {24'h0, got2}, 32'h34);
        checkOutput("two_word_rx_count", rx_count - rx0, 2);
        checkOutput("two_word_underrun", ur_count - ur0, 0);

        $display("[TB] abort after 5 bits");
        rx0 = rx_count;
        startFrame();
        sendWord(8'hAA, 5, 1'b1, got1);
        checkOutput("abort_rx_count", rx_count - rx0, 0);
        checkOutput("abort_rx_data", {24'h0, rx_data}, {24'h0, exp_last_rx});
        checkOutput("abort_busy", {31'h0, busy}, 32'h0);
        checkOutput("abort_miso_oe", {31'h0, miso_oe}, 32'h0);
        checkOutput("abort_miso", {31'h0, miso}, 32'h0);
        applyStimulus('{8'h66, 1'b1, 8'h81, 8'h66, 0});

        $display("[TB] reset mid-frame");
        rx0 = rx_count;
        startFrame();
        sendWord(8'hE0, 3, 1'b0, got1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrst_miso", {31'h0, miso}, 32'h0);
        checkOutput("midrst_miso_oe", {31'h0, miso_oe}, 32'h0);
        checkOutput("midrst_tx_ready", {31'h0, tx_ready}, 32'h1);
        checkOutput("midrst_rx_data", {24'h0, rx_data}, 32'h0);
        checkOutput("midrst_rx_valid", {31'h0, rx_valid}, 32'h0);
        checkOutput("midrst_tx_underrun", {31'h0, tx_underrun}, 32'h0);
        checkOutput("midrst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        sendWord(8'h1F, 5, 1'b1, got1);
        checkOutput("midrst_tail_rx_count", rx_count - rx0, 0);
        checkOutput("midrst_tail_rx_data", {24'h0, rx_data}, 32'h0);
        applyStimulus('{8'h42, 1'b1, 8'hE7, 8'h42, 0});

        $display("[TB] load collisions");
        loadTx(8'h11);
        tx_data = 8'h99;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        checkOutput("collide_tx_ready", {31'h0, tx_ready}, 32'h0);
        applyStimulus('{8'h00, 1'b0, 8'h3A, 8'h11, 0});

        rx0 = rx_count;
        ur0 = ur_count;
        exp_rx_q.push_back(8'h24);
        exp_rx_q.push_back(8'h99);
        ss = 1'b0;
        repeat (3) @(negedge clk);
        tx_data = 8'h5C;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        checkOutput("load_in_load_tx_ready", {31'h0, tx_ready}, 32'h0);
        sendWord(8'h24, 8, 1'b0, got1);
        sendWord(8'h99, 8, 1'b1, got2);
        checkOutput("load_in_load_miso0", {24'h0, got1}, 32'hFF);
        checkOutput("load_in_load_miso1", {24'h0, got2}, 32'h5C);
        checkOutput("load_in_load_underrun", ur_count - ur0, 1);
        checkOutput("load_in_load_rx_count", rx_count - rx0, 2);
        checkOutput("load_in_load_tx_ready_end", {31'h0, tx_ready}, 32'h1);

        checkOutput("scoreboard_empty", exp_rx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
